// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, field-width derivation and
// the divider's sequencer states.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTA = 3'd1;
    localparam logic [2:0] RM_RTP = 3'd2;
    localparam logic [2:0] RM_RTN = 3'd3;
    localparam logic [2:0] RM_RTZ = 3'd4;

    typedef enum logic [2:0] {IDLE, DIV, NORM, ROUND, DONE} divState_t;

    // Exponent field width for the supported operand widths (32/64/128).
    function automatic int expWidthOf(input int bitWidth);
        if (bitWidth == 32)      return 8;
        else if (bitWidth == 64) return 11;
        else                     return 15;
    endfunction

    // Significand width including the hidden bit.
    function automatic int sgnWidthOf(input int bitWidth);
        return bitWidth - expWidthOf(bitWidth);
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Combinational rounder shared by the FPU divider and multiplier.
// Takes a normalized mantissa with guard/sticky and returns the rounded
// fraction field plus the carry-out into the exponent.
import fpu_pkg::*;

module fpu_round #(
    parameter int SGN_WIDTH = 24
) (
    input  logic [SGN_WIDTH-1:0] mantIn,
    input  logic                 guard,
    input  logic                 sticky,
    input  logic                 sign,
    input  logic [2:0]           mode,
    output logic [SGN_WIDTH-2:0] fracOut,
    output logic                 carry,
    output logic                 inexact
);

    logic roundUp;

    // Increment decision per rounding mode; unused codes behave as RNE.
    always_comb begin
        roundUp = 1'b0;
        case (mode)
            RM_RTA:  roundUp = guard;
            RM_RTP:  roundUp = ~sign & (guard | sticky);
            RM_RTN:  roundUp = sign & (guard | sticky);
            RM_RTZ:  roundUp = 1'b0;
            default: roundUp = guard & (sticky | mantIn[0]);
        endcase
    end

    // An all-ones mantissa wraps the fraction to zero and carries, i.e. 1.000...
    assign fracOut = mantIn[SGN_WIDTH-2:0] + {{(SGN_WIDTH-2){1'b0}}, roundUp};
    assign carry   = roundUp & (&mantIn);
    assign inexact = guard | sticky;

endmodule

// File: rtl/fpu_div.sv
// Iterative IEEE-754 divider, radix-2 restoring, one quotient bit per clock.
// Flush-to-zero, no denormals; same mode encoding as the FPU multiplier.
// Optional build macro FPU_DIV_EARLY_EXIT_EN: zero operands skip the divide
// loop and complete two cycles after accept (results unchanged).
import fpu_pkg::*;

module fpu_div #(
    parameter int BIT_WIDTH = 128
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [2:0]           i_mode,
    input  logic [BIT_WIDTH-1:0] i_inputA,
    input  logic [BIT_WIDTH-1:0] i_inputB,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_output,
    output logic                 o_inexact,
    output logic                 o_div_by_zero
);

    localparam int EW    = expWidthOf(BIT_WIDTH);
    localparam int SW    = sgnWidthOf(BIT_WIDTH);
    localparam int FW    = SW - 1;
    localparam int BIAS  = 2**(EW-1) - 1;
    localparam int CNT_W = $clog2(SW + 2);
    localparam logic signed [EW+1:0] BIAS_E  = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] EXP_MAX = (EW+2)'((2**EW) - 1);

    divState_t state, nextState;

    logic                   signQ, zeroA, zeroB;
    logic [EW-1:0]          expA, expB;
    logic [SW-1:0]          mB;
    logic [SW:0]            rem;
    logic [SW+1:0]          quo;
    logic [2:0]             mode;
    logic [CNT_W-1:0]       cnt;
    logic [SW-1:0]          normMant;
    logic                   normGuard, normSticky;
    logic signed [EW+1:0]   normExp;

    logic                   accept, qBit;
    logic [SW:0]            remDiff, remNext;
    logic signed [EW+1:0]   expBase, expFin;
    logic [FW-1:0]          roundFrac;
    logic                   roundCarry, roundInexact;

    assign accept  = (state == IDLE) && i_start;
    assign o_busy  = (state != IDLE);
    assign o_valid = (state == DONE);

    // One restoring step: compare, conditionally subtract, then double.
    assign remDiff = rem - {1'b0, mB};
    assign qBit    = (rem >= {1'b0, mB});
    assign remNext = qBit ? remDiff : rem;

    assign expBase = $signed({2'b00, expA}) - $signed({2'b00, expB}) + BIAS_E;
    assign expFin  = normExp + $signed({{(EW+1){1'b0}}, roundCarry});

    fpu_round #(.SGN_WIDTH(SW)) uRound (
        .mantIn  (normMant),
        .guard   (normGuard),
        .sticky  (normSticky),
        .sign    (signQ),
        .mode    (mode),
        .fracOut (roundFrac),
        .carry   (roundCarry),
        .inexact (roundInexact)
    );

    // Sequencer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= nextState;
    end

`ifdef FPU_DIV_EARLY_EXIT_EN
    logic special;
    assign special = ~|i_inputA[BIT_WIDTH-2:0] | ~|i_inputB[BIT_WIDTH-2:0];
`endif

    // Next-state: fixed walk through the divide loop, NORM, ROUND, DONE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (i_start) begin
`ifdef FPU_DIV_EARLY_EXIT_EN
                    // Zero operands bypass the loop; NORM keeps valid at accept+2.
                    nextState = special ? NORM : DIV;
`else
                    nextState = DIV;
`endif
                end
            end
            DIV:     if (cnt == '0) nextState = NORM;
            NORM:    nextState = ROUND;
            ROUND:   nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: operand capture, divide loop, normalize, round/pack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            signQ         <= 1'b0;
            zeroA         <= 1'b0;
            zeroB         <= 1'b0;
            expA          <= '0;
            expB          <= '0;
            mB            <= '0;
            rem           <= '0;
            quo           <= '0;
            mode          <= '0;
            cnt           <= '0;
            normMant      <= '0;
            normGuard     <= 1'b0;
            normSticky    <= 1'b0;
            normExp       <= '0;
            o_output      <= '0;
            o_inexact     <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                signQ <= i_inputA[BIT_WIDTH-1] ^ i_inputB[BIT_WIDTH-1];
                zeroA <= ~|i_inputA[BIT_WIDTH-2:0];
                zeroB <= ~|i_inputB[BIT_WIDTH-2:0];
                expA  <= i_inputA[BIT_WIDTH-2:FW];
                expB  <= i_inputB[BIT_WIDTH-2:FW];
                rem   <= {2'b01, i_inputA[FW-1:0]};
                mB    <= {1'b1, i_inputB[FW-1:0]};
                quo   <= '0;
                mode  <= i_mode;
                cnt   <= CNT_W'(SW + 1);
            end
            if (state == DIV) begin
                quo <= {quo[SW:0], qBit};
                rem <= remNext << 1;
                cnt <= cnt - 1'b1;
            end
            if (state == NORM) begin
                if (quo[SW+1]) begin
                    normMant   <= quo[SW+1:2];
                    normGuard  <= quo[1];
                    normSticky <= quo[0] | (|rem);
                    normExp    <= expBase;
                end else begin
                    normMant   <= quo[SW:1];
                    normGuard  <= quo[0];
                    normSticky <= |rem;
                    normExp    <= expBase - (EW+2)'(1);
                end
            end
            if (state == ROUND) begin
                o_div_by_zero <= zeroB;
                if (zeroA && zeroB) begin
                    o_output  <= {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
                    o_inexact <= 1'b0;
                end else if (zeroB) begin
                    o_output  <= {signQ, {EW{1'b1}}, {FW{1'b0}}};
                    o_inexact <= 1'b0;
                end else if (zeroA) begin
                    o_output  <= {signQ, {(BIT_WIDTH-1){1'b0}}};
                    o_inexact <= 1'b0;
                end else if (expFin >= EXP_MAX) begin
                    o_output  <= {signQ, {EW{1'b1}}, {FW{1'b0}}};
                    o_inexact <= 1'b1;
                end else if (expFin <= 0) begin
                    o_output  <= {signQ, {(BIT_WIDTH-1){1'b0}}};
                    o_inexact <= 1'b1;
                end else begin
                    o_output  <= {signQ, expFin[EW-1:0], roundFrac};
                    o_inexact <= roundInexact;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_div.sv
// Directed bench for fpu_div at 32 bits: vector table plus hand sequences
// for handshake, hold, busy-time starts and mid-divide reset.
module tb_fpu_div;

    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rstN, start;
    logic [2:0]    mode;
    logic [BW-1:0] a, b;
    logic          busy, valid, inexact, dbz;
    logic [BW-1:0] out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [31:0] expOut;
        logic        expInx;
        logic        expDbz;
    } vec_t;

    vec_t vecs[18];

    fpu_div #(.BIT_WIDTH(BW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start),
        .i_mode        (mode),
        .i_inputA      (a),
        .i_inputB      (b),
        .o_busy        (busy),
        .o_valid       (valid),
        .o_output      (out),
        .o_inexact     (inexact),
        .o_div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doOp(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vm,
                        output logic [31:0] res, output logic rInx, output logic rDbz,
                        output int lat);
        int waitCnt = 0;
        while (busy && waitCnt < 300) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        a = va; b = vb; mode = vm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand changes while busy must not disturb the result.
        a = 32'hDEADBEEF; b = 32'h12345678; mode = 3'd4;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (valid) break;
        end
        res = out; rInx = inexact; rDbz = dbz;
    endtask

    function automatic int expLat(input logic [31:0] va, input logic [31:0] vb);
`ifdef FPU_DIV_EARLY_EXIT_EN
        if (va[30:0] == 31'd0 || vb[30:0] == 31'd0) return 2;
`endif
        return 28;
    endfunction

    initial begin
        logic [31:0] res;
        logic        rInx, rDbz;
        int          lat, n, pulses;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 1'b1, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAA, 1'b1, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAB, 1'b1, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAA, 1'b1, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAB, 1'b1, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 1'b1, 1'b0};
        vecs[7]  = '{32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAB, 1'b1, 1'b0};
        vecs[8]  = '{32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAA, 1'b1, 1'b0};
        vecs[9]  = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 1'b0, 1'b1};
        vecs[10] = '{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 1'b0, 1'b1};
        vecs[11] = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b1};
        vecs[12] = '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 1'b1, 1'b0};
        vecs[14] = '{32'h00800000, 32'h7F000000, 3'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[15] = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 1'b0, 1'b0};
        vecs[16] = '{32'h3F800000, 32'h3F7FFFFF, 3'd0, 32'h3F800001, 1'b1, 1'b0};
        vecs[17] = '{32'h3F800000, 32'h3F7FFFFF, 3'd4, 32'h3F800000, 1'b1, 1'b0};

        rstN = 1'b0; start = 1'b0; mode = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",    {31'd0, busy},    32'd0);
        check("reset valid",   {31'd0, valid},   32'd0);
        check("reset output",  out,              32'd0);
        check("reset inexact", {31'd0, inexact}, 32'd0);
        check("reset dbz",     {31'd0, dbz},     32'd0);
        rstN = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            doOp(vecs[i].a, vecs[i].b, vecs[i].mode, res, rInx, rDbz, lat);
            check($sformatf("vec%0d output", i),  res,            vecs[i].expOut);
            check($sformatf("vec%0d inexact", i), {31'd0, rInx},  {31'd0, vecs[i].expInx});
            check($sformatf("vec%0d dbz", i),     {31'd0, rDbz},  {31'd0, vecs[i].expDbz});
            check($sformatf("vec%0d latency", i), lat,            expLat(vecs[i].a, vecs[i].b));
        end

        // Handshake: busy after accept, one-cycle valid, start in DONE ignored, hold.
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40400000; mode = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs busy after accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (!valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("hs valid seen",  {31'd0, valid}, 32'd1);
        check("hs output",      out,            32'h3EAAAAAB);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs valid pulse width", {31'd0, valid}, 32'd0);
        check("hs busy after done",   {31'd0, busy},  32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hs done-cycle start ignored", {31'd0, busy}, 32'd0);
        check("hs output hold",              out,           32'h3EAAAAAB);

        // Start pulses while busy must not yield an extra result.
        a = 32'h3F800000; b = 32'h40400000; mode = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        a = 32'h40C00000; b = 32'h40000000; mode = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("busy start pulses", pulses, 1);
        check("busy start output", out,    32'h3EAAAAAA);

        // Asynchronous reset in the middle of a divide.
        a = 32'h40C00000; b = 32'h40000000; mode = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("mid reset busy",   {31'd0, busy},  32'd0);
        check("mid reset valid",  {31'd0, valid}, 32'd0);
        check("mid reset output", out,            32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        check("mid reset no valid", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
